// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types for the memory arbiter: FSM state encoding and the encoding
// used to name which port owns (or is being granted) the memory bus.
// -----------------------------------------------------------------------------
package riscv_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERV_IF = 2'd1,
        SERV_D  = 2'd2
    } arb_state_e;

    // Port-owner encoding for grant decisions.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } port_owner_e;

    // Width of the fetch-starvation counter (STARVE_MAX must fit).
    localparam int STARVE_W = 4;

    // Width of the optional statistics counters.
    localparam int STAT_W = 32;

endpackage

// File: rtl/mem_arb_prio.sv
// -----------------------------------------------------------------------------
// mem_arb_prio
// Grant decision for the memory arbiter. Data requests win by default, but
// once STARVE_MAX consecutive data grants have been made while a fetch was
// waiting, the fetch port is served next.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   idle_i       arbiter is in IDLE (the only state where grants happen)
//   if_req_i     instruction-fetch request
//   d_req_i      data request
//   grant_o      port granted this cycle (OWN_NONE when no grant)
// -----------------------------------------------------------------------------
module mem_arb_prio
    import riscv_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idle_i,
    input  logic        if_req_i,
    input  logic        d_req_i,
    output port_owner_e grant_o
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        grant_o      = OWN_NONE;
        starve_cnt_d = starve_cnt_q;
        if (idle_i) begin
            if (d_req_i && (!if_req_i || (starve_cnt_q < STARVE_LIM))) begin
                grant_o = OWN_D;
                if (if_req_i) begin
                    // Fetch is being passed over: count it, saturating.
                    if (starve_cnt_q < STARVE_LIM) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end else if (if_req_i) begin
                grant_o      = OWN_IF;
                starve_cnt_d = '0;
            end else begin
                // No fetch waiting, nothing to be starved.
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples its inputs from before the edge.
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates one memory port between an instruction-fetch port and a data
// port. One transaction at a time: a grant in IDLE registers the request onto
// m_*, which is held until m_ack; the served port sees valid/rdata
// combinationally in the m_ack cycle, then the FSM spends one IDLE cycle
// before the next grant.
//
// Optional feature: define MEM_ARB_STATS_EN to add 32-bit wrapping counters
// stat_if_grants, stat_d_grants and stat_conflicts (IDLE cycles with both
// requests pending).
//
// Ports:
//   clk, rst_n                            clock, async active-low reset
//   if_req/if_addr                        fetch request (held until if_valid)
//   if_valid/if_rdata/if_stall            fetch completion, data, waiting
//   d_req/d_we/d_addr/d_wdata             data request (held until d_valid)
//   d_valid/d_rdata/d_stall               data completion, data, waiting
//   m_req/m_we/m_addr/m_wdata             registered memory request
//   m_ack/m_rdata                         memory completion and read data
//   stat_*                                statistics (MEM_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_if_grants,
    output logic [STAT_W-1:0] stat_d_grants,
    output logic [STAT_W-1:0] stat_conflicts
`endif
);

    arb_state_e        state_q;
    logic              m_req_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    port_owner_e       grant;
    logic              idle;

    assign idle = (state_q == IDLE);

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .idle_i   (idle),
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .grant_o  (grant)
    );

    // FSM and memory-side request registers. m_ack outside a service state
    // is ignored, which also covers an ack arriving after a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    case (grant)
                        OWN_D: begin
                            state_q   <= SERV_D;
                            m_req_q   <= 1'b1;
                            m_we_q    <= d_we;
                            m_addr_q  <= d_addr;
                            m_wdata_q <= d_wdata;
                        end
                        OWN_IF: begin
                            state_q   <= SERV_IF;
                            m_req_q   <= 1'b1;
                            m_we_q    <= 1'b0;
                            m_addr_q  <= if_addr;
                            m_wdata_q <= '0;
                        end
                        default: begin
                            state_q <= IDLE;
                        end
                    endcase
                end
                SERV_IF, SERV_D: begin
                    // Request stays registered and stable until the ack.
                    if (m_ack) begin
                        state_q <= IDLE;
                        m_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

    // Completion is combinational on m_ack for the port in service only;
    // a requester that dropped its request still gets its valid pulse.
    assign if_valid = (state_q == SERV_IF) && m_ack;
    assign d_valid  = (state_q == SERV_D) && m_ack;
    assign if_rdata = if_valid ? m_rdata : '0;
    assign d_rdata  = d_valid ? m_rdata : '0;
    assign if_stall = if_req && !if_valid;
    assign d_stall  = d_req && !d_valid;

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_if_grants <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (grant == OWN_IF) begin
                stat_if_grants <= stat_if_grants + 32'd1;
            end
            if (grant == OWN_D) begin
                stat_d_grants <= stat_d_grants + 32'd1;
            end
            if (idle && if_req && d_req) begin
                stat_conflicts <= stat_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Inputs are driven and outputs sampled
// around the falling clock edge; the DUT updates on the rising edge. Each
// "cycle" below is one negedge-to-negedge window.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]       stat_if_grants;
    logic [31:0]       stat_d_grants;
    logic [31:0]       stat_conflicts;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .if_stall (if_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_valid  (d_valid),
        .d_rdata  (d_rdata),
        .d_stall  (d_stall),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants (stat_if_grants),
        .stat_d_grants  (stat_d_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    // Reset state, with a stray ack and nonzero read data on the bus.
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
        m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL reset_m_req got=%0h exp=0", m_req); end
        total++; if (m_we !== 1'b0) begin bad++; $display("FAIL reset_m_we got=%0h exp=0", m_we); end
        total++; if (m_addr !== 32'h0) begin bad++; $display("FAIL reset_m_addr got=%0h exp=0", m_addr); end
        total++; if (m_wdata !== 32'h0) begin bad++; $display("FAIL reset_m_wdata got=%0h exp=0", m_wdata); end
        total++; if ({if_valid, d_valid} !== 2'b00) begin bad++; $display("FAIL reset_valids got=%0b exp=00", {if_valid, d_valid}); end
        total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL reset_if_rdata got=%0h exp=0", if_rdata); end
        total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL reset_d_rdata got=%0h exp=0", d_rdata); end
        @(negedge clk);
        m_ack = 1'b0; rst_n = 1'b1;
    endtask

    // Fetch with memory ack two cycles after m_req rises.
    task automatic test_fetch();
        logic ack;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; d_req = 1'b0; m_ack = 1'b0; #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL fetch_c0_m_req got=%0h exp=0", m_req); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            ack = (c == 3);
            m_ack = ack; m_rdata = ack ? 32'h0050_0093 : 32'h0BAD_0000 + 32'(c); #1;
            total++; if (m_req !== 1'b1) begin bad++; $display("FAIL fetch_c%0d_m_req got=%0h exp=1", c, m_req); end
            total++; if (m_addr !== 32'h100 || m_we !== 1'b0) begin bad++; $display("FAIL fetch_c%0d_m_bus got=%0h/%0h exp=100/0", c, m_addr, m_we); end
            total++; if (if_valid !== ack || d_valid !== 1'b0) begin bad++; $display("FAIL fetch_c%0d_valid got=%0b%0b exp=%0b0", c, if_valid, d_valid, ack); end
            total++; if (if_rdata !== (ack ? 32'h0050_0093 : 32'h0)) begin bad++; $display("FAIL fetch_c%0d_rdata got=%0h", c, if_rdata); end
            total++; if (if_stall !== !ack) begin bad++; $display("FAIL fetch_c%0d_stall got=%0h exp=%0h", c, if_stall, !ack); end
        end
        @(negedge clk);
        if_req = 1'b0; m_ack = 1'b0; #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL fetch_after_m_req got=%0h exp=0", m_req); end
    endtask

    // Simultaneous requests: data first, then fetch after one IDLE cycle.
    task automatic test_conflict();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; m_ack = 1'b0; #1;
        total++; if (if_stall !== 1'b1 || d_stall !== 1'b1) begin bad++; $display("FAIL conf_c0_stall got=%0b%0b exp=11", if_stall, d_stall); end
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 32'hAAAA_0001; #1;
        total++; if (m_req !== 1'b1 || m_addr !== 32'h2000 || m_we !== 1'b0) begin bad++; $display("FAIL conf_first_grant got=%0h/%0h/%0h exp=1/2000/0", m_req, m_addr, m_we); end
        total++; if (d_valid !== 1'b1 || if_valid !== 1'b0 || d_rdata !== 32'hAAAA_0001) begin bad++; $display("FAIL conf_first_valid got=%0b%0b/%0h", if_valid, d_valid, d_rdata); end
        @(negedge clk);
        d_req = 1'b0; m_ack = 1'b0; #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL conf_idle_gap got=%0h exp=0", m_req); end
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 32'hAAAA_0002; #1;
        total++; if (m_req !== 1'b1 || m_addr !== 32'h300 || m_we !== 1'b0) begin bad++; $display("FAIL conf_second_grant got=%0h/%0h/%0h exp=1/300/0", m_req, m_addr, m_we); end
        total++; if (if_valid !== 1'b1 || d_valid !== 1'b0 || if_rdata !== 32'hAAAA_0002) begin bad++; $display("FAIL conf_second_valid got=%0b%0b/%0h", if_valid, d_valid, if_rdata); end
        @(negedge clk);
        if_req = 1'b0; m_ack = 1'b0;
    endtask

    // Store held for three service cycles.
    task automatic test_store();
        logic ack;
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; m_ack = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            ack = (c == 3);
            m_ack = ack; m_rdata = 32'h1234_5678; #1;
            total++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h40 || m_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_c%0d_bus got=%0h/%0h/%0h/%0h", c, m_req, m_we, m_addr, m_wdata); end
            total++; if (d_valid !== ack || if_valid !== 1'b0) begin bad++; $display("FAIL store_c%0d_valid got=%0b%0b exp=0%0b", c, if_valid, d_valid, ack); end
            total++; if (d_rdata !== (ack ? 32'h1234_5678 : 32'h0)) begin bad++; $display("FAIL store_c%0d_rdata got=%0h", c, d_rdata); end
        end
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
    endtask

    // Both ports held, zero-latency memory: D,D,D,D,IF repeating.
    task automatic test_starvation();
        bit exp_if;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        if_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0;
        for (int g = 0; g < 10; g++) begin
            exp_if = ((g % (STARVE_MAX + 1)) == STARVE_MAX);
            @(negedge clk);
            if_req = 1'b1; d_req = 1'b1; m_ack = 1'b0; #1;
            total++; if (m_req !== 1'b0) begin bad++; $display("FAIL starve_g%0d_idle got=%0h exp=0", g, m_req); end
            @(negedge clk);
            m_ack = 1'b1; m_rdata = 32'(g); #1;
            total++; if (if_valid !== exp_if || d_valid !== !exp_if) begin bad++; $display("FAIL starve_g%0d_owner got=%0b%0b exp=%0b%0b", g, if_valid, d_valid, exp_if, !exp_if); end
            total++; if (m_addr !== (exp_if ? 32'h1000 : 32'h2000)) begin bad++; $display("FAIL starve_g%0d_addr got=%0h", g, m_addr); end
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0; m_ack = 1'b0; #1;
`ifdef MEM_ARB_STATS_EN
        total++; if (stat_d_grants !== 32'd8) begin bad++; $display("FAIL stat_d_grants got=%0d exp=8", stat_d_grants); end
        total++; if (stat_if_grants !== 32'd2) begin bad++; $display("FAIL stat_if_grants got=%0d exp=2", stat_if_grants); end
        total++; if (stat_conflicts !== 32'd10) begin bad++; $display("FAIL stat_conflicts got=%0d exp=10", stat_conflicts); end
`endif
    endtask

    // Reset during SERV_D; a late ack must not produce a valid.
    task automatic test_reset_midop();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; m_ack = 1'b0;
        @(negedge clk); #1;
        total++; if (m_req !== 1'b1) begin bad++; $display("FAIL rmid_serving got=%0h exp=1", m_req); end
        @(negedge clk);
        rst_n = 1'b0; #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rmid_async_m_req got=%0h exp=0", m_req); end
        @(negedge clk);
        rst_n = 1'b1; d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h5555_5555; #1;
        total++; if ({if_valid, d_valid} !== 2'b00 || d_rdata !== 32'h0) begin bad++; $display("FAIL rmid_late_ack got=%0b%0b/%0h exp=00/0", if_valid, d_valid, d_rdata); end
        @(negedge clk);
        m_ack = 1'b0; if_req = 1'b1; if_addr = 32'h500; #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rmid_idle got=%0h exp=0", m_req); end
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 32'h600D_F00D; #1;
        total++; if (m_req !== 1'b1 || m_addr !== 32'h500 || if_valid !== 1'b1) begin bad++; $display("FAIL rmid_regrant got=%0h/%0h/%0h exp=1/500/1", m_req, m_addr, if_valid); end
        @(negedge clk);
        if_req = 1'b0; m_ack = 1'b0;
    endtask

    // Random traffic against a transaction-level model of the arbitration
    // rules: pending requests per port, a starvation count, random memory
    // latency, stray acks in IDLE and requests dropped mid-transaction.
    task automatic test_random();
        bit                if_pend = 0;
        bit                d_pend = 0;
        logic [ADDR_W-1:0] if_a = '0;
        logic [ADDR_W-1:0] d_a = '0;
        logic              d_w = 1'b0;
        logic [DATA_W-1:0] d_wd = '0;
        int                starve = 0;
        bit                win_d;
        bit                ack;
        int                lat;
        logic [ADDR_W-1:0] exp_addr;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (!if_pend && $urandom_range(0, 2) != 0) begin if_pend = 1; if_a = $urandom; end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1; d_a = $urandom; d_w = 1'($urandom_range(0, 1)); d_wd = $urandom;
            end
            if_req = if_pend; if_addr = if_a;
            d_req = d_pend; d_addr = d_a; d_we = d_w; d_wdata = d_wd;
            m_ack = ($urandom_range(0, 3) == 0); m_rdata = $urandom; #1;
            total++; if (m_req !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0) begin bad++; $display("FAIL rnd_idle t=%0d got=%0b%0b%0b exp=000", t, m_req, if_valid, d_valid); end
            total++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL rnd_idle_rdata t=%0d got=%0h/%0h exp=0/0", t, if_rdata, d_rdata); end
            if (!if_pend && !d_pend) begin
                starve = 0;
                continue;
            end
            win_d = d_pend && (!if_pend || starve < STARVE_MAX);
            if (win_d && if_pend) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
            else starve = 0;
            exp_addr = win_d ? d_a : if_a;
            lat = $urandom_range(0, 3);
            for (int c = 0; c <= lat; c++) begin
                @(negedge clk);
                ack = (c == lat);
                m_ack = ack; m_rdata = $urandom;
                if (c > 0 && $urandom_range(0, 5) == 0) begin
                    if (win_d) d_req = 1'b0;
                    else if_req = 1'b0;
                end
                #1;
                total++; if (m_req !== 1'b1 || m_addr !== exp_addr) begin bad++; $display("FAIL rnd_grant t=%0d c=%0d got=%0h/%0h exp=1/%0h", t, c, m_req, m_addr, exp_addr); end
                total++; if (m_we !== (win_d ? d_w : 1'b0)) begin bad++; $display("FAIL rnd_we t=%0d got=%0h exp=%0h", t, m_we, win_d ? d_w : 1'b0); end
                if (win_d) begin
                    total++; if (m_wdata !== d_wd) begin bad++; $display("FAIL rnd_wdata t=%0d got=%0h exp=%0h", t, m_wdata, d_wd); end
                end
                total++; if (if_valid !== (ack && !win_d) || d_valid !== (ack && win_d)) begin bad++; $display("FAIL rnd_valid t=%0d c=%0d got=%0b%0b exp=%0b%0b", t, c, if_valid, d_valid, ack && !win_d, ack && win_d); end
                total++; if (if_rdata !== ((ack && !win_d) ? m_rdata : 32'h0)) begin bad++; $display("FAIL rnd_if_rdata t=%0d got=%0h", t, if_rdata); end
                total++; if (d_rdata !== ((ack && win_d) ? m_rdata : 32'h0)) begin bad++; $display("FAIL rnd_d_rdata t=%0d got=%0h", t, d_rdata); end
                total++; if (if_stall !== (if_req && !(ack && !win_d)) || d_stall !== (d_req && !(ack && win_d))) begin bad++; $display("FAIL rnd_stall t=%0d got=%0b%0b", t, if_stall, d_stall); end
            end
            if (win_d) d_pend = 0;
            else if_pend = 0;
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_conflict();
        test_store();
        test_starvation();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
